// File: rtl/baggage_drop_pkg.sv
// ============================================================================
//  Module   : baggage_drop_pkg
//  Brief    : State encoding, 7-segment glyphs and display decode shared by
//             the baggage drop controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package baggage_drop_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_COLD = 3'd1;
    localparam logic [2:0] ST_DROP = 3'd2;
    localparam logic [2:0] ST_LOCK = 3'd3;
    localparam logic [2:0] ST_HOT  = 3'd4;

    // Segment order is g..a on bit6..bit0, 1 = lit
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_O     = 7'h5C;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_T     = 7'h78;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Returns {digit1, digit2, digit3, digit4} for a state
    function automatic logic [27:0] state_glyphs(input logic [2:0] st);
        logic [27:0] g;
        g = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
        case (st)
            ST_COLD, ST_LOCK: g = {SEG_C, SEG_O, SEG_L, SEG_D};
            ST_DROP:          g = {SEG_D, SEG_R, SEG_O, SEG_P};
            ST_HOT:           g = {SEG_BLANK, SEG_H, SEG_O, SEG_T};
            default:          g = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
        endcase
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bd_temp_monitor.sv
// ============================================================================
//  Module   : bd_temp_monitor
//  Brief    : Combinational over-temperature compare with exit hysteresis.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bd_temp_monitor #(
    parameter int T_WIDTH = 16,
    parameter int HYST    = 4
) (
    input  logic [T_WIDTH-1:0] t_act,
    input  logic [T_WIDTH-1:0] t_lim,
    output logic               hot_enter,
    output logic               hot_exit
);

    localparam logic [T_WIDTH:0] c_hyst = (T_WIDTH+1)'(HYST);

    logic [T_WIDTH:0] w_act_plus_hyst;

    // One extra bit so t_act near full scale cannot wrap into a false exit
    assign w_act_plus_hyst = {1'b0, t_act} + c_hyst;
    assign hot_enter       = t_act > t_lim;
    assign hot_exit        = w_act_plus_hyst <= {1'b0, t_lim};

endmodule

`default_nettype wire

// File: rtl/baggage_drop_ctrl.sv
// ============================================================================
//  Module   : baggage_drop_ctrl
//  Brief    : Clocked drop controller: hysteresis temperature FSM, drop
//             request qualification, timed drop pulse and drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baggage_drop_ctrl
    import baggage_drop_pkg::*;
#(
    parameter int T_WIDTH     = 16,
    parameter int HYST        = 4,
    parameter int EN_SETTLE   = 3,
    parameter int DROP_CYCLES = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [T_WIDTH-1:0]   t_act,
    input  logic [T_WIDTH-1:0]   t_lim,
    input  logic                 drop_en,
    output logic [6:0]           seven_seg1,
    output logic [6:0]           seven_seg2,
    output logic [6:0]           seven_seg3,
    output logic [6:0]           seven_seg4,
    output logic                 drop_activated,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int c_set_w = $clog2(EN_SETTLE + 1);
    localparam int c_drp_w = $clog2(DROP_CYCLES + 1);
    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(EN_SETTLE - 1);
    localparam logic [c_drp_w-1:0] c_drop_last   = c_drp_w'(DROP_CYCLES - 1);

    logic                 w_hot_enter;
    logic                 w_hot_exit;
    logic [2:0]           w_state_nxt;
    logic [c_set_w-1:0]   w_settle_nxt;
    logic [c_drp_w-1:0]   w_tmr_nxt;
    logic                 w_cnt_bump;

    logic [2:0]           r_state;
    logic [c_set_w-1:0]   r_settle;
    logic [c_drp_w-1:0]   r_tmr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [27:0]          r_seg;
    logic                 r_act;

    bd_temp_monitor #(
        .T_WIDTH (T_WIDTH),
        .HYST    (HYST)
    ) u_temp_monitor (
        .t_act     (t_act),
        .t_lim     (t_lim),
        .hot_enter (w_hot_enter),
        .hot_exit  (w_hot_exit)
    );

    // Timers default to zero so any entry into COLD or DROP starts fresh
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = '0;
        w_tmr_nxt    = '0;
        w_cnt_bump   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = w_hot_enter ? ST_HOT : ST_COLD;
            end
            ST_COLD: begin
                if (w_hot_enter) begin
                    w_state_nxt = ST_HOT;
                end else if (drop_en) begin
                    if (r_settle == c_settle_last) begin
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_settle_nxt = r_settle + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (w_hot_enter) begin
                    w_state_nxt = ST_HOT;
                end else if (r_tmr == c_drop_last) begin
                    w_state_nxt = ST_LOCK;
                    w_cnt_bump  = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            ST_LOCK: begin
                if (w_hot_enter) begin
                    w_state_nxt = ST_HOT;
                end else if (!drop_en) begin
                    w_state_nxt = ST_COLD;
                end
            end
            ST_HOT: begin
                // A request still held after cool-down must be released first
                if (w_hot_exit) begin
                    w_state_nxt = drop_en ? ST_LOCK : ST_COLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decode next-state so they change on the same edge as r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_tmr    <= '0;
            r_cnt    <= '0;
            r_seg    <= {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
            r_act    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
            r_tmr    <= w_tmr_nxt;
            r_seg    <= state_glyphs(w_state_nxt);
            r_act    <= (w_state_nxt == ST_DROP);
            if (w_cnt_bump && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign seven_seg1     = r_seg[27:21];
    assign seven_seg2     = r_seg[20:14];
    assign seven_seg3     = r_seg[13:7];
    assign seven_seg4     = r_seg[6:0];
    assign drop_activated = r_act;
    assign state_o        = r_state;
    assign drop_cnt       = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_baggage_drop_ctrl.sv
// ============================================================================
//  Module   : tb_baggage_drop_ctrl
//  Brief    : Self-checking bench for baggage_drop_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baggage_drop_ctrl;

    localparam logic [2:0] E_IDLE = 3'd0;
    localparam logic [2:0] E_COLD = 3'd1;
    localparam logic [2:0] E_DROP = 3'd2;
    localparam logic [2:0] E_LOCK = 3'd3;
    localparam logic [2:0] E_HOT  = 3'd4;

    typedef struct {
        logic [2:0]  st;
        logic [27:0] seg;
        logic        act;
        logic [7:0]  cnt;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        drop_en;
    logic [6:0]  seven_seg1;
    logic [6:0]  seven_seg2;
    logic [6:0]  seven_seg3;
    logic [6:0]  seven_seg4;
    logic        drop_activated;
    logic [2:0]  state_o;
    logic [7:0]  drop_cnt;

    exp_t        exp_q[$];
    int          n_tests;
    int          n_fail;
    logic [7:0]  exp_cnt;
    logic [2:0]  last_exp_st;

    baggage_drop_ctrl #(
        .T_WIDTH     (16),
        .HYST        (4),
        .EN_SETTLE   (3),
        .DROP_CYCLES (8),
        .CNT_WIDTH   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .t_act          (t_act),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .seven_seg1     (seven_seg1),
        .seven_seg2     (seven_seg2),
        .seven_seg3     (seven_seg3),
        .seven_seg4     (seven_seg4),
        .drop_activated (drop_activated),
        .state_o        (state_o),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] glyphs_of(input logic [2:0] st);
        case (st)
            E_COLD, E_LOCK: return 28'h0;
            default:        return 28'h0;
        endcase
    endfunction

    function automatic logic [27:0] expect_segs(input logic [2:0] st);
        logic [27:0] g;
        g = glyphs_of(st);
        case (st)
            E_IDLE:         g = {7'h40, 7'h40, 7'h40, 7'h40};
            E_COLD, E_LOCK: g = {7'h39, 7'h5C, 7'h38, 7'h5E};
            E_DROP:         g = {7'h5E, 7'h50, 7'h5C, 7'h73};
            E_HOT:          g = {7'h00, 7'h76, 7'h5C, 7'h78};
            default:        g = 28'hFFFFFFF;
        endcase
        return g;
    endfunction

    // One clock: queue the expected post-edge outputs, then compare them
    task automatic cycle(input logic en, input logic [2:0] st_exp, input string tag);
        exp_t e;
        exp_t got;
        logic [27:0] segs;
        drop_en = en;
        if (last_exp_st == E_DROP && st_exp == E_LOCK && exp_cnt != 8'hFF) begin
            exp_cnt = exp_cnt + 8'd1;
        end
        last_exp_st = st_exp;
        e.st  = st_exp;
        e.seg = expect_segs(st_exp);
        e.act = (st_exp == E_DROP);
        e.cnt = exp_cnt;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = exp_q.pop_front();
        segs = {seven_seg1, seven_seg2, seven_seg3, seven_seg4};
        n_tests++;
        if (state_o !== got.st) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", got.tag, state_o, got.st);
        end
        n_tests++;
        if (segs !== got.seg) begin
            n_fail++;
            $display("FAIL %s segs: got %h expected %h", got.tag, segs, got.seg);
        end
        n_tests++;
        if (drop_activated !== got.act) begin
            n_fail++;
            $display("FAIL %s drop_activated: got %b expected %b", got.tag, drop_activated, got.act);
        end
        n_tests++;
        if (drop_cnt !== got.cnt) begin
            n_fail++;
            $display("FAIL %s drop_cnt: got %0d expected %0d", got.tag, drop_cnt, got.cnt);
        end
    endtask

    // Drop from COLD with drop_en held: settle, 8-cycle pulse, LOCK
    task automatic full_drop(input string tag);
        cycle(1'b1, E_COLD, tag);
        cycle(1'b1, E_COLD, tag);
        cycle(1'b1, E_DROP, tag);
        for (int i = 0; i < 7; i++) cycle(1'b1, E_DROP, tag);
        cycle(1'b1, E_LOCK, tag);
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if ({seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            n_fail++;
            $display("FAIL %s segs: got %h expected %h", tag,
                     {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, {7'h40, 7'h40, 7'h40, 7'h40});
        end
        n_tests++;
        if (drop_activated !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drop_activated: got %b expected 0", tag, drop_activated);
        end
        n_tests++;
        if (drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL %s drop_cnt: got %0d expected 0", tag, drop_cnt);
        end
        n_tests++;
        if (state_o !== E_IDLE) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected 0", tag, state_o);
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        t_act   = 16'd20;
        t_lim   = 16'd30;
        drop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_values("idle_after_release");
        exp_cnt     = 8'd0;
        last_exp_st = E_IDLE;
        cycle(1'b0, E_COLD, "idle_to_cold");
        cycle(1'b0, E_COLD, "cold_hold");
    endtask

    task automatic test_settle;
        cycle(1'b1, E_COLD, "settle_b1_1");
        cycle(1'b1, E_COLD, "settle_b1_2");
        cycle(1'b0, E_COLD, "settle_gap");
        cycle(1'b1, E_COLD, "settle_b2_1");
        cycle(1'b1, E_COLD, "settle_b2_2");
        cycle(1'b1, E_DROP, "settle_b2_3");
        // Request level is ignored while the pulse runs
        for (int i = 0; i < 7; i++) cycle((i == 3) ? 1'b0 : 1'b1, E_DROP, "drop_pulse");
        cycle(1'b1, E_LOCK, "drop_done");
    endtask

    task automatic test_lockout;
        for (int i = 0; i < 20; i++) cycle(1'b1, E_LOCK, "lock_hold");
        cycle(1'b0, E_COLD, "lock_release");
        full_drop("second_drop");
        cycle(1'b0, E_COLD, "second_release");
    endtask

    task automatic test_abort;
        cycle(1'b1, E_COLD, "abort_settle");
        cycle(1'b1, E_COLD, "abort_settle");
        cycle(1'b1, E_DROP, "abort_enter");
        cycle(1'b1, E_DROP, "abort_mid");
        cycle(1'b1, E_DROP, "abort_mid");
        cycle(1'b1, E_DROP, "abort_mid");
        t_act = 16'd31;
        cycle(1'b1, E_HOT, "abort_hot");
    endtask

    task automatic test_hysteresis;
        t_act = 16'd30;
        cycle(1'b1, E_HOT, "hyst_30");
        t_act = 16'd27;
        cycle(1'b1, E_HOT, "hyst_27");
        t_act = 16'd26;
        cycle(1'b1, E_LOCK, "hyst_26_en");
        t_act = 16'd30;
        cycle(1'b1, E_LOCK, "lock_at_limit");
        t_act = 16'd31;
        cycle(1'b1, E_HOT, "lock_to_hot");
        t_act = 16'd26;
        cycle(1'b0, E_COLD, "hyst_26_noen");
        t_act = 16'd30;
        cycle(1'b0, E_COLD, "cold_at_limit");
        // Near full scale: a 16-bit wrap of t_act+HYST would exit falsely
        t_lim = 16'hFFFE;
        t_act = 16'hFFFF;
        cycle(1'b0, E_HOT, "top_hot");
        t_act = 16'hFFFD;
        cycle(1'b0, E_HOT, "top_nowrap");
        t_act = 16'd20;
        t_lim = 16'd30;
        cycle(1'b0, E_COLD, "top_cooled");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 258; i++) begin
            full_drop("sat_drop");
            cycle(1'b0, E_COLD, "sat_release");
        end
        n_tests++;
        if (exp_cnt !== 8'hFF || drop_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturation: got %0d expected 255", drop_cnt);
        end
    endtask

    task automatic test_async_reset;
        cycle(1'b1, E_COLD, "ar_settle");
        cycle(1'b1, E_COLD, "ar_settle");
        cycle(1'b1, E_DROP, "ar_enter");
        cycle(1'b1, E_DROP, "ar_mid");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n       = 1'b1;
        drop_en     = 1'b0;
        exp_cnt     = 8'd0;
        last_exp_st = E_IDLE;
        cycle(1'b0, E_COLD, "ar_recover");
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        exp_cnt     = 8'd0;
        last_exp_st = E_IDLE;
        rst_n       = 1'b0;
        t_act       = 16'd20;
        t_lim       = 16'd30;
        drop_en     = 1'b0;
        test_reset();
        test_settle();
        test_lockout();
        test_abort();
        test_hysteresis();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
